// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_MAX_CH = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_id_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Channel-side request/grant/response bundle plus the single SRAM port.
interface mem_port_arbiter_if #(
    parameter int NB_CH      = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [NB_CH-1:0]                  ch_req_i;
    logic [NB_CH-1:0]                  ch_lock_i;
    logic [NB_CH-1:0][ADDR_WIDTH-1:0]  ch_addr_i;
    logic [NB_CH-1:0]                  ch_we_i;
    logic [NB_CH-1:0][BE_W-1:0]        ch_be_i;
    logic [NB_CH-1:0][DATA_WIDTH-1:0]  ch_wdata_i;
    logic [NB_CH-1:0]                  ch_gnt_o;
    logic [NB_CH-1:0]                  ch_rvalid_o;
    logic [DATA_WIDTH-1:0]             ch_rdata_o;

    logic                              mem_en_o;
    logic [ADDR_WIDTH-1:0]             mem_addr_o;
    logic                              mem_we_o;
    logic [BE_W-1:0]                   mem_be_o;
    logic [DATA_WIDTH-1:0]             mem_wdata_o;
    logic [DATA_WIDTH-1:0]             mem_rdata_i;

    modport slave (
        input  ch_req_i, ch_lock_i, ch_addr_i, ch_we_i, ch_be_i, ch_wdata_i, mem_rdata_i,
        output ch_gnt_o, ch_rvalid_o, ch_rdata_o,
        output mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output ch_req_i, ch_lock_i, ch_addr_i, ch_we_i, ch_be_i, ch_wdata_i, mem_rdata_i,
        input  ch_gnt_o, ch_rvalid_o, ch_rdata_o,
        input  mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Rotating-priority picker: first eligible request at or after ptr_i, wrapping.
module mem_arb_rr #(
    parameter int NB_CH = 4,
    parameter int CH_W  = 2
) (
    input  logic [NB_CH-1:0] req_i,
    input  logic [NB_CH-1:0] mask_i,
    input  logic [CH_W-1:0]  ptr_i,
    output logic [NB_CH-1:0] gnt_o,
    output logic [CH_W-1:0]  idx_o,
    output logic             vld_o
);

    logic [NB_CH-1:0] elig;
    logic [CH_W-1:0]  cand;
    int               pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        pos   = 0;
        elig  = req_i & mask_i;
        for (int i = 0; i < NB_CH; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= NB_CH) pos = pos - NB_CH;
            cand = CH_W'(pos);
            if (!vld_o && elig[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel round-robin SRAM arbiter with bounded lock and in-order response routing.
// Optional per-channel grant counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NB_CH      = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_port_arbiter_if.slave       bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    input  logic                    perf_clr_i,
    output logic [NB_CH-1:0][31:0]  perf_cnt_o
`endif
);

    localparam int CH_W          = ch_id_w(NB_CH);
    localparam int BE_W          = DATA_WIDTH / 8;
    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

    arb_state_e       state;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  owner;
    logic [7:0]       lock_cnt;

    logic [NB_CH-1:0] elig_mask;
    logic [NB_CH-1:0] gnt;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_any;

    logic [RD_LATENCY:1]           vld_pipe;
    logic [RD_LATENCY:1][CH_W-1:0] id_pipe;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    function automatic logic [NB_CH-1:0] to_onehot(input logic [CH_W-1:0] i);
        to_onehot    = '0;
        to_onehot[i] = 1'b1;
    endfunction

    function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] k);
        return (k == CH_W'(NB_CH - 1)) ? '0 : k + 1'b1;
    endfunction

    // Reset masks every request so nothing is granted while rst is high.
    always_comb begin
        if (rst)                      elig_mask = '0;
        else if (state == ARB_LOCKED) elig_mask = to_onehot(owner);
        else                          elig_mask = '1;
    end

    mem_arb_rr #(
        .NB_CH (NB_CH),
        .CH_W  (CH_W)
    ) u_rr (
        .req_i  (bus.ch_req_i),
        .mask_i (elig_mask),
        .ptr_i  (rr_ptr),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .vld_o  (gnt_any)
    );

    // A locked owner that still requests but drops lock gets this last grant, then releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gnt_any) begin
                        rr_ptr <= ch_next(gnt_idx);
                        if (bus.ch_lock_i[gnt_idx] && (MAX_LOCK > 1)) begin
                            state    <= ARB_LOCKED;
                            owner    <= gnt_idx;
                            lock_cnt <= 8'd1;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (!gnt_any || !bus.ch_lock_i[owner] || (lock_cnt == LOCK_LAST)) begin
                        state    <= ARB_IDLE;
                        rr_ptr   <= ch_next(owner);
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= gnt_any;
            id_pipe[1]  <= gnt_idx;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // SRAM lines keep their last driven value while idle to avoid toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (gnt_any) begin
            addr_q  <= bus.ch_addr_i[gnt_idx];
            we_q    <= bus.ch_we_i[gnt_idx];
            be_q    <= bus.ch_be_i[gnt_idx];
            wdata_q <= bus.ch_wdata_i[gnt_idx];
        end
    end

    always_comb begin
        bus.ch_gnt_o    = gnt;
        bus.mem_en_o    = gnt_any;
        bus.mem_addr_o  = gnt_any ? bus.ch_addr_i[gnt_idx]  : addr_q;
        bus.mem_we_o    = gnt_any ? bus.ch_we_i[gnt_idx]    : we_q;
        bus.mem_be_o    = gnt_any ? bus.ch_be_i[gnt_idx]    : be_q;
        bus.mem_wdata_o = gnt_any ? bus.ch_wdata_i[gnt_idx] : wdata_q;
        bus.ch_rvalid_o = (!rst && vld_pipe[RD_LATENCY]) ? to_onehot(id_pipe[RD_LATENCY]) : '0;
        bus.ch_rdata_o  = bus.mem_rdata_i;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    for (genvar g = 0; g < NB_CH; g++) begin : g_perf
        always_ff @(posedge clk) begin
            if (rst || perf_clr_i)
                perf_cnt_o[g] <= '0;
            else if (gnt[g] && (perf_cnt_o[g] != '1))
                perf_cnt_o[g] <= perf_cnt_o[g] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue/array reference model.
// Perf-counter checks are built when MEM_ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;

    localparam int NB  = 4;
    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int RDL = 3;
    localparam int ML  = 3;
    localparam int MW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NB_CH(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic                perf_clr;
    logic [NB-1:0][31:0] perf_cnt;
`endif

    mem_port_arbiter #(
        .NB_CH(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .MAX_LOCK(ML)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_clr_i (perf_clr),
        .perf_cnt_o (perf_cnt)
`endif
    );

    // Behavioural SRAM: fixed read latency, byte-enabled writes.
    logic [DW-1:0] sram [MW];
    logic [DW-1:0] rd_q [RDL];
    assign bus.mem_rdata_i = rd_q[RDL-1];

    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < DW/8; b++)
                    if (bus.mem_be_o[b]) sram[bus.mem_addr_o[4:0]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            end else begin
                rd_q[0] <= sram[bus.mem_addr_o[4:0]];
            end
        end
        for (int i = 1; i < RDL; i++) rd_q[i] <= rd_q[i-1];
    end

    typedef struct {
        int            due;
        int            ch;
        bit            rd;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] refm [MW];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            m_ptr, m_owner, m_cnt;
    bit            m_locked;
    bit            have_last;
    logic [AW-1:0] last_addr;
    int            perf_m [NB];

    logic [NB-1:0]         nx_req, nx_lock, nx_we, s_req, s_lock;
    logic [NB-1:0][AW-1:0] nx_addr;
    logic [NB-1:0][3:0]    nx_be;
    logic [NB-1:0][DW-1:0] nx_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick();
        if (m_locked) return bus.ch_req_i[m_owner] ? m_owner : -1;
        for (int i = 0; i < NB; i++)
            if (bus.ch_req_i[(m_ptr + i) % NB]) return (m_ptr + i) % NB;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
        have_last = 0;
        rq.delete();
        for (int i = 0; i < NB; i++) perf_m[i] = 0;
    endtask

    task automatic stage_clear();
        nx_req = '0; nx_lock = '0; nx_we = '0;
        nx_addr = '0; nx_be = '0; nx_wdata = '0;
    endtask

    task automatic drive(input int mode);
        for (int c = 0; c < NB; c++) begin
            bus.ch_addr_i[c]  = AW'($urandom_range(0, MW-1));
            bus.ch_we_i[c]    = 1'($urandom_range(0, 1));
            bus.ch_be_i[c]    = 4'($urandom);
            bus.ch_wdata_i[c] = $urandom;
        end
        case (mode)
            0: begin bus.ch_req_i = '1; bus.ch_lock_i = '0; end
            1: begin
                bus.ch_req_i  = NB'($urandom);
                bus.ch_lock_i = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
            end
            2: begin
                for (int c = 0; c < NB; c++) begin
                    if ($urandom_range(0, 4) == 0) s_req[c]  = ~s_req[c];
                    if ($urandom_range(0, 4) == 0) s_lock[c] = ~s_lock[c];
                end
                bus.ch_req_i = s_req; bus.ch_lock_i = s_lock;
            end
            default: begin
                bus.ch_req_i = nx_req; bus.ch_lock_i = nx_lock; bus.ch_we_i = nx_we;
                bus.ch_addr_i = nx_addr; bus.ch_be_i = nx_be; bus.ch_wdata_i = nx_wdata;
            end
        endcase
    endtask

    task automatic step(input int mode);
        int            w;
        int            a;
        logic [NB-1:0] exp_rv;
        @(negedge clk);
        drive(mode);
        #1;
        w = pick();
        check("gnt", bus.ch_gnt_o, (w < 0) ? 64'd0 : (64'd1 << w));
        check("mem_en", bus.mem_en_o, (w >= 0));
        if (w >= 0) begin
            check("mem_addr", bus.mem_addr_o, bus.ch_addr_i[w]);
            check("mem_we", bus.mem_we_o, bus.ch_we_i[w]);
            if (bus.ch_we_i[w]) begin
                check("mem_wdata", bus.mem_wdata_o, bus.ch_wdata_i[w]);
                check("mem_be", bus.mem_be_o, bus.ch_be_i[w]);
            end
        end else if (have_last) begin
            check("hold_addr", bus.mem_addr_o, last_addr);
        end
        exp_rv = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rv[rq[0].ch] = 1'b1;
            if (rq[0].rd) check("rdata", bus.ch_rdata_o, rq[0].data);
            void'(rq.pop_front());
        end
        check("rvalid", bus.ch_rvalid_o, exp_rv);
        if (w >= 0) begin
            a = int'(bus.ch_addr_i[w]);
            rq.push_back('{cyc + RDL, w, !bus.ch_we_i[w], refm[a]});
            if (bus.ch_we_i[w])
                for (int b = 0; b < 4; b++)
                    if (bus.ch_be_i[w][b]) refm[a][8*b +: 8] = bus.ch_wdata_i[w][8*b +: 8];
            last_addr = bus.ch_addr_i[w];
            have_last = 1;
            perf_m[w]++;
        end
        if (!m_locked) begin
            if (w >= 0) begin
                m_ptr = (w + 1) % NB;
                if (bus.ch_lock_i[w] && ML > 1) begin
                    m_locked = 1; m_owner = w; m_cnt = 1;
                end
            end
        end else begin
            if (w >= 0 && bus.ch_lock_i[m_owner]) m_cnt++;
            if (w < 0 || !bus.ch_lock_i[m_owner] || m_cnt >= ML) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % NB;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ch_req_i = '1;
        bus.ch_lock_i = '0;
        repeat (3) begin
            #1;
            check("rst_gnt", bus.ch_gnt_o, 0);
            check("rst_en", bus.mem_en_o, 0);
            check("rst_rvalid", bus.ch_rvalid_o, 0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.ch_req_i = '0;
        model_reset();
        @(posedge clk);
        cyc++;
    endtask

    task automatic flush();
        stage_clear();
        repeat (RDL + 1) step(3);
    endtask

    initial begin
        rst = 1'b1;
        bus.ch_req_i = '0; bus.ch_lock_i = '0; bus.ch_we_i = '0;
        bus.ch_addr_i = '0; bus.ch_be_i = '0; bus.ch_wdata_i = '0;
        s_req = '0; s_lock = '0;
        for (int i = 0; i < MW; i++) begin sram[i] = '0; refm[i] = '0; end
        for (int i = 0; i < RDL; i++) rd_q[i] = '0;
`ifdef MEM_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        model_reset();
        do_reset();

        // all channels requesting, no lock: plain rotation
        repeat (8) step(0);

        // ch2 locks against ch0, then ch3 competes with ch2
        stage_clear();
        nx_req = 4'b0101; nx_lock = 4'b0100;
        repeat (5) step(3);
        nx_req = 4'b1100; nx_lock = 4'b0000;
        repeat (3) step(3);
        flush();

        // write on ch1, read back on ch3
        stage_clear();
        nx_req[1] = 1'b1; nx_we[1] = 1'b1; nx_addr[1] = AW'(16);
        nx_be[1] = 4'hF; nx_wdata[1] = 32'hDEADBEEF;
        step(3);
        stage_clear();
        nx_req[3] = 1'b1; nx_addr[3] = AW'(16);
        step(3);
        flush();

        repeat (300) step(1);
        repeat (300) step(2);

        // back-to-back reads, then reset with responses outstanding
        stage_clear();
        nx_req = 4'b0011;
        for (int c = 0; c < NB; c++) nx_addr[c] = AW'(c);
        repeat (3) step(3);
        do_reset();
        repeat (6) step(0);
        repeat (200) step(1);
        flush();

`ifdef MEM_ARB_PERF_CNT_EN
        do_reset();
        stage_clear();
        nx_req[1] = 1'b1;
        repeat (5) step(3);
        stage_clear();
        step(3);
        check("perf_cnt1", perf_cnt[1], perf_m[1]);
        check("perf_cnt0", perf_cnt[0], perf_m[0]);
        @(negedge clk); perf_clr = 1'b1;
        @(posedge clk);
        @(negedge clk); perf_clr = 1'b0;
        #1;
        check("perf_clr", perf_cnt[1], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
